shared_ram_arbiter: RTL and testbench

- Single-port arbiter for the 4KB inter-core shared-memory RAM (mailbox region) sitting beside the partitioned data RAM.
- Shares one single-port block RAM between an RT-Core requester and a GP-Core requester. Both requesters are already synchronised into the 100MHz domain.
- Policy: RT fixed priority, with bounded GP starvation and per-owner atomic lock for read-modify-write.
- Out-of-range and misaligned accesses are bounds-checked and answered with an error response.

---
 rtl/shm_arb_pkg.sv | 27 ++
 rtl/shm_addr_check.sv | 27 ++
 rtl/shared_ram_arbiter.sv | 278 +++++++++++++++++++++++++++
 tb/tb_shared_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shm_arb_pkg.sv
// Shared definitions for the inter-core shared-memory (mailbox) RAM arbiter.
package shm_arb_pkg;

  // Arbiter FSM states; encoding 2'd3 is unused and recovers to ARB_OPEN.
  typedef enum logic [1:0] {
    ARB_OPEN      = 2'd0,
    ARB_RT_LOCKED = 2'd1,
    ARB_GP_LOCKED = 2'd2
  } arb_state_t;

  // Which requester owns the response returned one cycle after a grant.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    RT   = 2'd1,
    GP   = 2'd2
  } owner_t;

  // Read data returned for an out-of-range or misaligned access.
  localparam logic [31:0] SHM_ERR_PATTERN = 32'hDEAD_BEEF;

  // Default placement and sizing of the shared region.
  localparam logic [31:0] SHM_DEFAULT_BASE         = 32'h0003_0000;
  localparam int          SHM_DEFAULT_SIZE         = 32'sd4096;
  localparam int          SHM_DEFAULT_STARVE_LIMIT = 32'sd4;
  localparam int          SHM_DEFAULT_LOCK_MAX     = 32'sd16;

endpackage

// File: rtl/shm_addr_check.sv
// Bounds and alignment check of one requester byte address against the
// shared region, plus translation to a RAM word address.
module shm_addr_check
  import shm_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32'sd32,
  parameter logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(SHM_DEFAULT_BASE),
  parameter int                    SIZE       = SHM_DEFAULT_SIZE,
  parameter int                    RAM_AW     = 32'sd10
)(
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  valid,
  output logic [RAM_AW-1:0]     word_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = BASE + ADDR_WIDTH'(SIZE - 32'sd1);

  logic [ADDR_WIDTH-1:0] offset_s;

  // Region window check, word alignment and byte-to-word translation.
  always_comb begin
    offset_s  = addr - BASE;
    valid     = (addr >= BASE) && (addr <= LAST) && (addr[1:0] == 2'b00);
    word_addr = RAM_AW'(offset_s >> 2'd2);
  end

endmodule

// File: rtl/shared_ram_arbiter.sv
// Single-port RAM arbiter for the RT-Core / GP-Core shared mailbox region.
// RT has fixed priority; GP is forced through after a bounded number of lost
// conflicts; either side can hold an atomic lock that times out.
module shared_ram_arbiter
  import shm_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 32'sd32,
  parameter int                    DATA_WIDTH    = 32'sd32,
  parameter logic [ADDR_WIDTH-1:0] SHM_BASE_ADDR = ADDR_WIDTH'(SHM_DEFAULT_BASE),
  parameter int                    SHM_SIZE      = SHM_DEFAULT_SIZE,
  parameter int                    STARVE_LIMIT  = SHM_DEFAULT_STARVE_LIMIT,
  parameter int                    LOCK_MAX      = SHM_DEFAULT_LOCK_MAX,
  localparam int                   RAM_AW        = $clog2(SHM_SIZE / 32'sd4)
)(
  input  logic                  clk_gp_100mhz,
  input  logic                  rst_n,
  input  logic                  rt_req,
  input  logic                  rt_we,
  input  logic                  rt_lock,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  input  logic [DATA_WIDTH-1:0] rt_wdata,
  output logic                  rt_gnt,
  output logic                  rt_rvalid,
  output logic [DATA_WIDTH-1:0] rt_rdata,
  output logic                  rt_error,
  input  logic                  gp_req,
  input  logic                  gp_we,
  input  logic                  gp_lock,
  input  logic [ADDR_WIDTH-1:0] gp_addr,
  input  logic [DATA_WIDTH-1:0] gp_wdata,
  output logic                  gp_gnt,
  output logic                  gp_rvalid,
  output logic [DATA_WIDTH-1:0] gp_rdata,
  output logic                  gp_error,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [31:0]           rt_grant_count,
  output logic [31:0]           gp_grant_count,
  output logic                  starve_override,
  output logic                  lock_timeout,
  output logic [1:0]            arb_state
);

  localparam int                WAIT_W     = $clog2(STARVE_LIMIT + 32'sd1);
  localparam int                LOCK_W     = $clog2(LOCK_MAX + 32'sd1);
  localparam logic [WAIT_W-1:0] STARVE_CNT = WAIT_W'(STARVE_LIMIT);
  localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_MAX - 32'sd1);

  // Response payload: error pattern, echoed write data, or RAM read data.
  function automatic logic [DATA_WIDTH-1:0] resp_data(
    input logic                  err,
    input logic                  we,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] rdata
  );
    logic [DATA_WIDTH-1:0] res;
    if (err) begin
      res = DATA_WIDTH'(SHM_ERR_PATTERN);
    end else if (we) begin
      res = wdata;
    end else begin
      res = rdata;
    end
    return res;
  endfunction

  arb_state_t            state_q, state_d;
  logic [WAIT_W-1:0]     gp_wait_q, gp_wait_d;
  logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [31:0]           rt_cnt_q, rt_cnt_d;
  logic [31:0]           gp_cnt_q, gp_cnt_d;
  owner_t                resp_owner_q, resp_owner_d;
  logic                  resp_err_q, resp_err_d;
  logic                  resp_we_q, resp_we_d;
  logic [DATA_WIDTH-1:0] resp_wdata_q, resp_wdata_d;

  logic                  rt_valid_s, gp_valid_s;
  logic [RAM_AW-1:0]     rt_waddr_s, gp_waddr_s;
  logic                  rt_win_s, gp_win_s;
  logic                  starve_s, timeout_s;
  logic [DATA_WIDTH-1:0] resp_data_s;

  shm_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE       (SHM_BASE_ADDR),
    .SIZE       (SHM_SIZE),
    .RAM_AW     (RAM_AW)
  ) u_rt_check (
    .addr      (rt_addr),
    .valid     (rt_valid_s),
    .word_addr (rt_waddr_s)
  );

  shm_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE       (SHM_BASE_ADDR),
    .SIZE       (SHM_SIZE),
    .RAM_AW     (RAM_AW)
  ) u_gp_check (
    .addr      (gp_addr),
    .valid     (gp_valid_s),
    .word_addr (gp_waddr_s)
  );

  // Arbitration decision and next FSM state; nothing is granted under reset.
  always_comb begin
    rt_win_s  = 1'b0;
    gp_win_s  = 1'b0;
    starve_s  = 1'b0;
    timeout_s = 1'b0;
    state_d   = ARB_OPEN;
    if (rst_n) begin
      case (state_q)
        ARB_OPEN: begin
          if (rt_req && gp_req) begin
            if (gp_wait_q == STARVE_CNT) begin
              gp_win_s = 1'b1;
              starve_s = 1'b1;
            end else begin
              rt_win_s = 1'b1;
            end
          end else if (rt_req) begin
            rt_win_s = 1'b1;
          end else if (gp_req) begin
            gp_win_s = 1'b1;
          end else begin
            rt_win_s = 1'b0;
          end
          if (rt_win_s && rt_lock) begin
            state_d = ARB_RT_LOCKED;
          end else if (gp_win_s && gp_lock) begin
            state_d = ARB_GP_LOCKED;
          end else begin
            state_d = ARB_OPEN;
          end
        end
        ARB_RT_LOCKED: begin
          rt_win_s = rt_req;
          if (lock_cnt_q == LOCK_LAST) begin
            timeout_s = 1'b1;
            state_d   = ARB_OPEN;
          end else if (rt_win_s && !rt_lock) begin
            state_d = ARB_OPEN;
          end else begin
            state_d = ARB_RT_LOCKED;
          end
        end
        ARB_GP_LOCKED: begin
          gp_win_s = gp_req;
          if (lock_cnt_q == LOCK_LAST) begin
            timeout_s = 1'b1;
            state_d   = ARB_OPEN;
          end else if (gp_win_s && !gp_lock) begin
            state_d = ARB_OPEN;
          end else begin
            state_d = ARB_GP_LOCKED;
          end
        end
        default: begin
          state_d = ARB_OPEN;
        end
      endcase
    end else begin
      state_d = ARB_OPEN;
    end
  end

  // Grants, debug pulses and the RAM strobe; invalid accesses never reach RAM.
  always_comb begin
    rt_gnt          = rt_win_s;
    gp_gnt          = gp_win_s;
    starve_override = starve_s;
    lock_timeout    = timeout_s;
    ram_en          = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    if (rt_win_s && rt_valid_s) begin
      ram_en    = 1'b1;
      ram_we    = rt_we;
      ram_addr  = rt_waddr_s;
      ram_wdata = rt_wdata;
    end else if (gp_win_s && gp_valid_s) begin
      ram_en    = 1'b1;
      ram_we    = gp_we;
      ram_addr  = gp_waddr_s;
      ram_wdata = gp_wdata;
    end else begin
      ram_en = 1'b0;
    end
  end

  // Next values of the starvation/lock counters, grant counters and response tag.
  always_comb begin
    gp_wait_d    = gp_wait_q;
    lock_cnt_d   = '0;
    rt_cnt_d     = rt_cnt_q + 32'(rt_win_s);
    gp_cnt_d     = gp_cnt_q + 32'(gp_win_s);
    resp_owner_d = NONE;
    resp_err_d   = 1'b0;
    resp_we_d    = 1'b0;
    resp_wdata_d = '0;

    if (gp_win_s) begin
      gp_wait_d = '0;
    end else if (state_q == ARB_RT_LOCKED) begin
      gp_wait_d = gp_wait_q;
    end else if (gp_req && (gp_wait_q != STARVE_CNT)) begin
      gp_wait_d = gp_wait_q + WAIT_W'(1'b1);
    end else begin
      gp_wait_d = gp_wait_q;
    end

    if (((state_q == ARB_RT_LOCKED) || (state_q == ARB_GP_LOCKED)) &&
        (state_d != ARB_OPEN)) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1'b1);
    end else begin
      lock_cnt_d = '0;
    end

    if (rt_win_s) begin
      resp_owner_d = RT;
      resp_err_d   = !rt_valid_s;
      resp_we_d    = rt_we;
      resp_wdata_d = rt_wdata;
    end else if (gp_win_s) begin
      resp_owner_d = GP;
      resp_err_d   = !gp_valid_s;
      resp_we_d    = gp_we;
      resp_wdata_d = gp_wdata;
    end else begin
      resp_owner_d = NONE;
    end
  end

  // State, counters and response tag registers; reset drops any pending response.
  always_ff @(posedge clk_gp_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_OPEN;
      gp_wait_q    <= '0;
      lock_cnt_q   <= '0;
      rt_cnt_q     <= 32'd0;
      gp_cnt_q     <= 32'd0;
      resp_owner_q <= NONE;
      resp_err_q   <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      gp_wait_q    <= gp_wait_d;
      lock_cnt_q   <= lock_cnt_d;
      rt_cnt_q     <= rt_cnt_d;
      gp_cnt_q     <= gp_cnt_d;
      resp_owner_q <= resp_owner_d;
      resp_err_q   <= resp_err_d;
      resp_we_q    <= resp_we_d;
      resp_wdata_q <= resp_wdata_d;
    end
  end

  // Response steering: only the tagged owner sees rvalid and data.
  always_comb begin
    resp_data_s    = resp_data(resp_err_q, resp_we_q, resp_wdata_q, ram_rdata);
    rt_rvalid      = (resp_owner_q == RT);
    gp_rvalid      = (resp_owner_q == GP);
    rt_rdata       = rt_rvalid ? resp_data_s : '0;
    gp_rdata       = gp_rvalid ? resp_data_s : '0;
    rt_error       = rt_rvalid & resp_err_q;
    gp_error       = gp_rvalid & resp_err_q;
    rt_grant_count = rt_cnt_q;
    gp_grant_count = gp_cnt_q;
    arb_state      = state_q;
  end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed self-checking bench for shared_ram_arbiter with a 1-cycle RAM model.
module tb_shared_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rt_req = 1'b0, rt_we = 1'b0, rt_lock = 1'b0;
  logic [31:0] rt_addr = 32'd0, rt_wdata = 32'd0;
  logic        gp_req = 1'b0, gp_we = 1'b0, gp_lock = 1'b0;
  logic [31:0] gp_addr = 32'd0, gp_wdata = 32'd0;
  logic        rt_gnt, rt_rvalid, rt_error, gp_gnt, gp_rvalid, gp_error;
  logic [31:0] rt_rdata, gp_rdata;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'd0;
  logic [31:0] rt_grant_count, gp_grant_count;
  logic        starve_override, lock_timeout;
  logic [1:0]  arb_state;

  logic [31:0] mem [0:1023];

  int checks_cnt = 0;
  int errors_cnt = 0;

  shared_ram_arbiter dut (
    .clk_gp_100mhz   (clk),
    .rst_n           (rst_n),
    .rt_req          (rt_req),
    .rt_we           (rt_we),
    .rt_lock         (rt_lock),
    .rt_addr         (rt_addr),
    .rt_wdata        (rt_wdata),
    .rt_gnt          (rt_gnt),
    .rt_rvalid       (rt_rvalid),
    .rt_rdata        (rt_rdata),
    .rt_error        (rt_error),
    .gp_req          (gp_req),
    .gp_we           (gp_we),
    .gp_lock         (gp_lock),
    .gp_addr         (gp_addr),
    .gp_wdata        (gp_wdata),
    .gp_gnt          (gp_gnt),
    .gp_rvalid       (gp_rvalid),
    .gp_rdata        (gp_rdata),
    .gp_error        (gp_error),
    .ram_en          (ram_en),
    .ram_we          (ram_we),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata),
    .rt_grant_count  (rt_grant_count),
    .gp_grant_count  (gp_grant_count),
    .starve_override (starve_override),
    .lock_timeout    (lock_timeout),
    .arb_state       (arb_state)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Single-port RAM, read-first, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rt(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
    rt_req = req; rt_we = we; rt_lock = lock; rt_addr = addr; rt_wdata = wdata;
  endtask

  task automatic set_gp(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
    gp_req = req; gp_we = we; gp_lock = lock; gp_addr = addr; gp_wdata = wdata;
  endtask

  task automatic idle_all();
    set_rt(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_gp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_rt_gnt", {31'd0, rt_gnt}, 32'd0);
    check_eq("rst_rt_rvalid", {31'd0, rt_rvalid}, 32'd0);
    check_eq("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check_eq("rst_arb_state", {30'd0, arb_state}, 32'd0);
    check_eq("rst_rt_count", rt_grant_count, 32'd0);
    rst_n = 1'b1;
    cyc();

    // RT write then read of 0x30010
    set_rt(1'b1, 1'b1, 1'b0, 32'h0003_0010, 32'h1122_3344);
    #1;
    check_eq("t1_wr_gnt", {31'd0, rt_gnt}, 32'd1);
    check_eq("t1_wr_ram_en", {31'd0, ram_en}, 32'd1);
    check_eq("t1_wr_ram_we", {31'd0, ram_we}, 32'd1);
    check_eq("t1_wr_ram_addr", {22'd0, ram_addr}, 32'd4);
    check_eq("t1_wr_ram_wdata", ram_wdata, 32'h1122_3344);
    cyc();
    check_eq("t1_wr_rvalid", {31'd0, rt_rvalid}, 32'd1);
    check_eq("t1_wr_echo", rt_rdata, 32'h1122_3344);
    check_eq("t1_wr_error", {31'd0, rt_error}, 32'd0);
    set_rt(1'b1, 1'b0, 1'b0, 32'h0003_0010, 32'd0);
    #1;
    check_eq("t1_rd_gnt", {31'd0, rt_gnt}, 32'd1);
    check_eq("t1_rd_ram_we", {31'd0, ram_we}, 32'd0);
    check_eq("t1_rd_ram_addr", {22'd0, ram_addr}, 32'd4);
    cyc();
    check_eq("t1_rd_rvalid", {31'd0, rt_rvalid}, 32'd1);
    check_eq("t1_rd_data", rt_rdata, 32'h1122_3344);
    check_eq("t1_rd_gp_rvalid", {31'd0, gp_rvalid}, 32'd0);
    idle_all();
    cyc();

    // Starvation: both requesting for 6 cycles
    set_rt(1'b1, 1'b0, 1'b0, 32'h0003_0020, 32'd0);
    set_gp(1'b1, 1'b0, 1'b0, 32'h0003_0024, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check_eq("t2_rt_rvalid", {31'd0, rt_rvalid}, (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
      check_eq("t2_gp_rvalid", {31'd0, gp_rvalid}, (i == 5) ? 32'd1 : 32'd0);
      #1;
      check_eq("t2_rt_gnt", {31'd0, rt_gnt}, (i == 4) ? 32'd0 : 32'd1);
      check_eq("t2_gp_gnt", {31'd0, gp_gnt}, (i == 4) ? 32'd1 : 32'd0);
      check_eq("t2_starve", {31'd0, starve_override}, (i == 4) ? 32'd1 : 32'd0);
      cyc();
    end
    idle_all();
    check_eq("t2_last_rt_rvalid", {31'd0, rt_rvalid}, 32'd1);
    cyc();

    // GP locked read, RT blocked until GP unlock write
    set_gp(1'b1, 1'b0, 1'b1, 32'h0003_0000, 32'd0);
    #1;
    check_eq("t3_gp_lock_gnt", {31'd0, gp_gnt}, 32'd1);
    cyc();
    check_eq("t3_state_gp_locked", {30'd0, arb_state}, 32'd2);
    check_eq("t3_gp_rvalid", {31'd0, gp_rvalid}, 32'd1);
    set_gp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_rt(1'b1, 1'b0, 1'b0, 32'h0003_0010, 32'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("t3_rt_blocked", {31'd0, rt_gnt}, 32'd0);
      cyc();
    end
    set_gp(1'b1, 1'b1, 1'b0, 32'h0003_0004, 32'hA5A5_0001);
    #1;
    check_eq("t3_gp_unlock_gnt", {31'd0, gp_gnt}, 32'd1);
    check_eq("t3_rt_still_blocked", {31'd0, rt_gnt}, 32'd0);
    cyc();
    set_gp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check_eq("t3_rt_gnt_after", {31'd0, rt_gnt}, 32'd1);
    check_eq("t3_state_open", {30'd0, arb_state}, 32'd0);
    check_eq("t3_gp_wr_echo", gp_rdata, 32'hA5A5_0001);
    cyc();
    check_eq("t3_rt_rd_data", rt_rdata, 32'h1122_3344);
    idle_all();
    cyc();

    // RT lock held without release: timeout after 16 locked cycles
    set_rt(1'b1, 1'b0, 1'b1, 32'h0003_0008, 32'd0);
    #1;
    check_eq("t4_rt_lock_gnt", {31'd0, rt_gnt}, 32'd1);
    cyc();
    set_rt(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    set_gp(1'b1, 1'b0, 1'b0, 32'h0003_0004, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      #1;
      check_eq("t4_gp_blocked", {31'd0, gp_gnt}, 32'd0);
      check_eq("t4_lock_timeout", {31'd0, lock_timeout}, (k == 16) ? 32'd1 : 32'd0);
      check_eq("t4_state_rt_locked", {30'd0, arb_state}, 32'd1);
      cyc();
    end
    #1;
    check_eq("t4_gp_gnt_after", {31'd0, gp_gnt}, 32'd1);
    check_eq("t4_state_open", {30'd0, arb_state}, 32'd0);
    check_eq("t4_timeout_cleared", {31'd0, lock_timeout}, 32'd0);
    cyc();
    set_gp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("t4_gp_rvalid", {31'd0, gp_rvalid}, 32'd1);
    check_eq("t4_gp_rd_data", gp_rdata, 32'hA5A5_0001);
    idle_all();
    cyc();

    // Out-of-range and misaligned GP reads, then last valid word
    set_gp(1'b1, 1'b0, 1'b0, 32'h0003_1000, 32'd0);
    #1;
    check_eq("t5_oor_gnt", {31'd0, gp_gnt}, 32'd1);
    check_eq("t5_oor_ram_en", {31'd0, ram_en}, 32'd0);
    cyc();
    set_gp(1'b1, 1'b0, 1'b0, 32'h0003_0002, 32'd0);
    check_eq("t5_oor_rvalid", {31'd0, gp_rvalid}, 32'd1);
    check_eq("t5_oor_rdata", gp_rdata, 32'hDEAD_BEEF);
    check_eq("t5_oor_error", {31'd0, gp_error}, 32'd1);
    #1;
    check_eq("t5_mis_gnt", {31'd0, gp_gnt}, 32'd1);
    check_eq("t5_mis_ram_en", {31'd0, ram_en}, 32'd0);
    cyc();
    set_gp(1'b1, 1'b0, 1'b0, 32'h0003_0FFC, 32'd0);
    check_eq("t5_mis_rvalid", {31'd0, gp_rvalid}, 32'd1);
    check_eq("t5_mis_rdata", gp_rdata, 32'hDEAD_BEEF);
    check_eq("t5_mis_error", {31'd0, gp_error}, 32'd1);
    #1;
    check_eq("t5_last_ram_en", {31'd0, ram_en}, 32'd1);
    check_eq("t5_last_ram_addr", {22'd0, ram_addr}, 32'h0000_03FF);
    cyc();
    idle_all();
    check_eq("t5_last_rvalid", {31'd0, gp_rvalid}, 32'd1);
    check_eq("t5_last_error", {31'd0, gp_error}, 32'd0);
    cyc();

    // Grant counters across all previous accesses
    check_eq("rt_grant_count", rt_grant_count, 32'd9);
    check_eq("gp_grant_count", gp_grant_count, 32'd7);

    // Reset right after an RT read grant: no response follows
    set_rt(1'b1, 1'b0, 1'b0, 32'h0003_0010, 32'd0);
    #1;
    check_eq("t6_gnt", {31'd0, rt_gnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_gnt_in_rst", {31'd0, rt_gnt}, 32'd0);
    check_eq("t6_ram_en_in_rst", {31'd0, ram_en}, 32'd0);
    cyc();
    check_eq("t6_rt_rvalid", {31'd0, rt_rvalid}, 32'd0);
    check_eq("t6_rt_rdata", rt_rdata, 32'd0);
    check_eq("t6_rt_count", rt_grant_count, 32'd0);
    check_eq("t6_gp_count", gp_grant_count, 32'd0);
    idle_all();
    rst_n = 1'b1;
    cyc();
    check_eq("t6_no_rvalid_after", {31'd0, rt_rvalid}, 32'd0);
    check_eq("t6_state_open", {30'd0, arb_state}, 32'd0);
    set_rt(1'b1, 1'b0, 1'b0, 32'h0003_0010, 32'd0);
    #1;
    check_eq("t6_regnt", {31'd0, rt_gnt}, 32'd1);
    cyc();
    idle_all();
    check_eq("t6_rd_data", rt_rdata, 32'h1122_3344);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
